// File: rtl/cotm32_mem_arbiter_pkg.sv
// Shared types and memory map for the cotm32 memory arbiter and its address decoder.
package cotm32_mem_arbiter_pkg;

   localparam int XLEN                = 32;
   localparam int ARB_TIMEOUT_DEFAULT = 16;

   localparam logic [XLEN-1:0] INST_MEM_START = 32'h0000_0000;
   localparam logic [XLEN-1:0] INST_MEM_END   = 32'h0000_0FFF;
   localparam logic [XLEN-1:0] DATA_MEM_START = 32'h1000_0000;
   localparam logic [XLEN-1:0] DATA_MEM_END   = 32'h1000_0FFF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_RSP,
      ST_FAULT
   } arb_state_t;

   typedef enum logic {
      ARB_IFU,
      ARB_LSU
   } arb_owner_t;

   function automatic logic in_window(input logic [XLEN-1:0] addr,
                                      input logic [XLEN-1:0] lo,
                                      input logic [XLEN-1:0] hi);
      return (addr >= lo) && (addr <= hi);
   endfunction

endpackage

// File: rtl/cotm32_mem_decode.sv
// Address legality check shared by every bus master: word aligned, inside a
// mapped window, and never a store into instruction memory.
module cotm32_mem_decode
   import cotm32_mem_arbiter_pkg::*;
(
   input  logic [XLEN-1:0] addr,
   input  logic            we,
   output logic            legal
);

   logic in_inst;
   logic in_data;
   logic aligned;

   assign in_inst = in_window(addr, INST_MEM_START, INST_MEM_END);
   assign in_data = in_window(addr, DATA_MEM_START, DATA_MEM_END);
   assign aligned = (addr[1:0] == 2'b00);
   assign legal   = aligned && (in_data || (in_inst && !we));

endmodule

// File: rtl/cotm32_mem_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store onto one memory
// port, with address decode, a single outstanding transaction and a timeout.
//
// state       | meaning
// ST_IDLE     | no transaction; grants issued combinationally here
// ST_ISSUE    | mem_req held with latched fields until mem_gnt
// ST_WAIT_RSP | request accepted, waiting for mem_rvalid
// ST_FAULT    | illegal access; error response next edge, no memory request
module cotm32_mem_arbiter
   import cotm32_mem_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            if_req,
   input  logic [XLEN-1:0] if_addr,
   output logic            if_gnt,
   output logic            if_rvalid,
   input  logic            ls_req,
   input  logic            ls_we,
   input  logic [3:0]      ls_be,
   input  logic [XLEN-1:0] ls_addr,
   input  logic [XLEN-1:0] ls_wdata,
   output logic            ls_gnt,
   output logic            ls_rvalid,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err,
   output logic            mem_req,
   output logic            mem_we,
   output logic [3:0]      mem_be,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   arb_state_t       state;
   arb_owner_t       owner;
   arb_owner_t       last_grant;
   logic [CNT_W-1:0] tmo_cnt;

   logic            grant_if;
   logic            grant_ls;
   logic [XLEN-1:0] g_addr;
   logic            g_we;
   logic            g_legal;

   // On a tie the requester that did not win last time gets the bus.
   assign grant_if = (state == ST_IDLE) && if_req && (!ls_req || (last_grant == ARB_LSU));
   assign grant_ls = (state == ST_IDLE) && ls_req && (!if_req || (last_grant == ARB_IFU));

   assign if_gnt = grant_if && !rst;
   assign ls_gnt = grant_ls && !rst;

   assign g_addr = grant_ls ? ls_addr : if_addr;
   assign g_we   = grant_ls && ls_we;

   cotm32_mem_decode u_decode (
      .addr  (g_addr),
      .we    (g_we),
      .legal (g_legal)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         owner      <= ARB_IFU;
         last_grant <= ARB_IFU;
         tmo_cnt    <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_be     <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_rvalid  <= 1'b0;
         ls_rvalid  <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_rdata  <= '0;
      end else begin
         if_rvalid <= 1'b0;
         ls_rvalid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;

         case (state)
            ST_IDLE: begin
               if (grant_if || grant_ls) begin
                  owner      <= grant_ls ? ARB_LSU : ARB_IFU;
                  last_grant <= grant_ls ? ARB_LSU : ARB_IFU;
                  mem_addr   <= g_addr;
                  mem_we     <= g_we;
                  mem_be     <= grant_ls ? ls_be : 4'b1111;
                  mem_wdata  <= grant_ls ? ls_wdata : '0;
                  tmo_cnt    <= '0;
                  if (g_legal) begin
                     mem_req <= 1'b1;
                     state   <= ST_ISSUE;
                  end else begin
                     state   <= ST_FAULT;
                  end
               end
            end

            ST_ISSUE: begin
               if (tmo_cnt == CNT_LAST) begin
                  mem_req   <= 1'b0;
                  if_rvalid <= (owner == ARB_IFU);
                  ls_rvalid <= (owner == ARB_LSU);
                  rsp_err   <= 1'b1;
                  state     <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
                  if (mem_gnt) begin
                     mem_req <= 1'b0;
                     state   <= ST_WAIT_RSP;
                  end
               end
            end

            ST_WAIT_RSP: begin
               // A response arriving on the final budgeted cycle still counts.
               if (mem_rvalid) begin
                  if_rvalid <= (owner == ARB_IFU);
                  ls_rvalid <= (owner == ARB_LSU);
                  rsp_rdata <= mem_we ? '0 : mem_rdata;
                  state     <= ST_IDLE;
               end else if (tmo_cnt == CNT_LAST) begin
                  if_rvalid <= (owner == ARB_IFU);
                  ls_rvalid <= (owner == ARB_LSU);
                  rsp_err   <= 1'b1;
                  state     <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end

            ST_FAULT: begin
               if_rvalid <= (owner == ARB_IFU);
               ls_rvalid <= (owner == ARB_LSU);
               rsp_err   <= 1'b1;
               state     <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/cotm32_mem_arbiter.md
COTM32_MEM_ARBITER -- requirements
Module: cotm32_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max cycles from entering ISSUE to mem_rvalid before the transaction is faulted.
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port if_req  in  1  fetch request, held until if_gnt.
REQ-005 SHALL have port if_addr  in  XLEN  fetch word address.
REQ-006 SHALL have port if_gnt  out  1  fetch request accepted this cycle.
REQ-007 SHALL have port if_rvalid  out  1  fetch response valid, one cycle.
REQ-008 SHALL have port ls_req  in  1  LSU request, held until ls_gnt.
REQ-009 SHALL have port ls_we  in  1  1 = store, 0 = load.
REQ-010 SHALL have port ls_be  in  4  byte enables.
REQ-011 SHALL have port ls_addr  in  XLEN  LSU word address.
REQ-012 SHALL have port ls_wdata  in  XLEN  store data.
REQ-013 SHALL have port ls_gnt  out  1  LSU request accepted this cycle.
REQ-014 SHALL have port ls_rvalid  out  1  LSU response valid, one cycle.
REQ-015 SHALL have port rsp_rdata  out  XLEN  response data, shared by both requesters.
REQ-016 SHALL have port rsp_err  out  1  access fault, qualified by if_rvalid/ls_rvalid.
REQ-017 SHALL have ports mem_req, mem_we (1), mem_be (4), mem_addr, mem_wdata (XLEN)  out  unified memory request.
REQ-018 SHALL have ports mem_gnt (1), mem_rvalid (1), mem_rdata (XLEN)  in  memory accept/response.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT_RSP, FAULT; one outstanding transaction max.
REQ-020 IDLE, one requester active: SHALL assert its gnt combinationally that cycle.
REQ-021 IDLE, both active: SHALL grant the requester not granted last (round-robin); last_grant resets to IFU, so LSU wins the first tie.
REQ-022 On grant SHALL latch owner, addr, we, be, wdata; IFU grants latch we=0, be=4'b1111, wdata=0.
REQ-023 Decode on grant: addr within INST_MEM_START..INST_MEM_END or DATA_MEM_START..DATA_MEM_END is legal; store to INST range, addr[1:0]!=0, or out-of-range SHALL go to FAULT, else ISSUE.
REQ-024 ISSUE: mem_req=1 with latched fields, held stable until mem_gnt=1, then WAIT_RSP.
REQ-025 WAIT_RSP: on mem_rvalid SHALL register owner rvalid=1, rsp_rdata=mem_rdata (0 for stores), rsp_err=0 next cycle; go IDLE.
REQ-026 FAULT: SHALL emit owner rvalid=1, rsp_err=1, rsp_rdata=0 next cycle without asserting mem_req; go IDLE.
REQ-027 Timeout counter SHALL clear on grant and count in ISSUE/WAIT_RSP; at TIMEOUT_CYCLES SHALL drop mem_req, emit err response as REQ-026, go IDLE.
REQ-028 mem_rvalid outside WAIT_RSP SHALL be ignored.
REQ-029 rvalid, rsp_err, rsp_rdata registered; rvalid high exactly one cycle; non-owner rvalid 0; rsp_rdata=0 when no rvalid.
REQ-030 FSM is in IDLE during the rvalid cycle; a new grant may occur that cycle (back-to-back).
REQ-031 gnt SHALL be 0 outside IDLE; min latency grant@T, mem_req@T+1, rvalid@T+3 with mem_gnt@T+1, mem_rvalid@T+2.

Reset
REQ-032 rst SHALL asynchronously force IDLE, last_grant=IFU, counter=0, latched fields=0; all outputs 0.
REQ-033 rst mid-transaction SHALL abandon it without any response; a pending mem_rvalid after release is ignored.

Structure
REQ-034 Shared package SHALL hold arb_state_t (4 states), arb_owner_t (ARB_IFU, ARB_LSU) and ARB_TIMEOUT_DEFAULT=16; memory map constants reused from the package.
REQ-035 Address decode SHALL be sub-module cotm32_mem_decode (addr, we -> legal) reused by other masters.

Verification
REQ-036 IFU fetch 0x0000_0010, mem_gnt immediate, mem_rdata=0x00000013 next cycle -> if_rvalid@T+3, rsp_rdata=0x00000013, err=0.
REQ-037 if_req and ls_req together after reset -> ls_gnt first; repeat the tie -> if_gnt; alternation holds over 4 ties.
REQ-038 LSU store to 0x0000_0004 -> no mem_req, ls_rvalid next cycle with rsp_err=1; load from 0x2000_0000 -> same.
REQ-039 LSU load 0x1000_0002 (misaligned) -> fault; load 0x1000_0FFC -> legal, mem_addr=0x1000_0FFC.
REQ-040 mem_gnt held 0 for 16 cycles -> mem_req drops, owner rvalid with rsp_err=1, FSM IDLE.
REQ-041 rst asserted in WAIT_RSP then mem_rvalid after release -> no rvalid; outputs 0 during reset.
